// File: rtl/mem_arbiter_if.sv
// Bus bundle between the unified-memory arbiter, its two requesters (cpu, ldr)
// and the single memory port.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the unified instruction/data memory:
// cpu has priority, a hold counter bounds how long a pending loader can starve.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_e;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
  localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_q, owner_d;
  logic [3:0]    hold_q, hold_d;
  logic [2:0]    wait_q, wait_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          grant_ldr;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can leave one unassigned (no latches).
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    grant_ldr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          grant_ldr = bus.ldr_req && (!bus.cpu_req || hold_q == HOLD_LIMIT);
          if (grant_ldr || !bus.ldr_req) begin
            hold_d = '0;
          end else if (hold_q != HOLD_LIMIT) begin
            hold_d = hold_q + 4'd1;
          end
          owner_d = grant_ldr;
          we_d    = grant_ldr ? bus.ldr_we    : bus.cpu_we;
          addr_d  = grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
          wdata_d = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else if (MEM_LAT == 1) begin
          state_d = CAPTURE;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 3'd1) begin
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      CAPTURE: begin
        if (owner_q) begin
          ldr_rdata_d = bus.mem_rdata;
        end else begin
          cpu_rdata_d = bus.mem_rdata;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      hold_q      <= '0;
      wait_q      <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Everything below is decoded from registers, so reset clears it immediately.
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = (state_q == RESP) && !owner_q;
  assign bus.ldr_ack   = (state_q == RESP) && owner_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level timeline model.
module tb_mem_arbiter;

  localparam int TB_LAT  = 3;
  localparam int TB_HOLD = 4;

  logic clk;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [31:0] exp_cpu_rd = '0;
  logic [31:0] exp_ldr_rd = '0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(TB_LAT), .MAX_HOLD(TB_HOLD)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE, 16'(i * 7 + 3)};
  endfunction

  // Memory: 256 words, read data presented exactly TB_LAT cycles after mem_en.
  logic [31:0] mem_arr [256];
  bit          written [256];
  logic [7:0]  pipe_idx [TB_LAT];
  logic        pipe_v   [TB_LAT];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
      written[bus.mem_addr[9:2]] <= 1'b1;
    end
    pipe_v[0]   <= bus.mem_en && !bus.mem_we;
    pipe_idx[0] <= bus.mem_addr[9:2];
    for (int i = 1; i < TB_LAT; i++) begin
      pipe_v[i]   <= pipe_v[i-1];
      pipe_idx[i] <= pipe_idx[i-1];
    end
  end

  assign bus.mem_rdata = (pipe_v[TB_LAT-1] !== 1'b1) ? 32'hDEAD0BAD :
                         written[pipe_idx[TB_LAT-1]] ? mem_arr[pipe_idx[TB_LAT-1]] :
                         init_word(int'(pipe_idx[TB_LAT-1]));

  task automatic drive(input bit who, input bit req, input bit we,
                       input logic [31:0] a, input logic [31:0] d);
    if (who) begin
      bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // One access from IDLE; n counts cycles after the IDLE cycle where req is sampled.
  task automatic do_access(input bit who, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input int chg_at, input logic [31:0] chg_a,
                           output int lat, output int en_at, output bit we_seen,
                           output int addr_bad, output int owner_bad);
    int n;
    lat = -1; en_at = -1; we_seen = 1'b0; addr_bad = 0; owner_bad = 0; n = 0;
    drive(who, 1'b1, we, a, d);
    while (lat < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_en === 1'b1 && en_at < 0) begin
        en_at   = n;
        we_seen = bus.mem_we;
      end
      if (bus.busy === 1'b1 && bus.mem_addr !== a) addr_bad++;
      if (bus.busy === 1'b1 && bus.owner !== who) owner_bad++;
      if ((who ? bus.ldr_ack : bus.cpu_ack) === 1'b1) begin
        lat = n;
        drive(who, 1'b0, 1'b0, '0, '0);
      end else if (n == chg_at) begin
        drive(who, 1'b1, we, chg_a, d);
      end
    end
    if (lat < 0) drive(who, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [133:0] outs;
    int lat, en_at, ab, ob, acks;
    bit we_s;
    repeat (2) @(negedge clk);
    outs = {bus.cpu_ack, bus.ldr_ack, bus.mem_en, bus.mem_we, bus.busy, bus.owner,
            bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.ldr_rdata};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL reset_outputs got %h want 0", outs); end
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.mem_en} !== 2'b10) begin
      miscompares++; $display("FAIL reset_in_wait busy/mem_en got %b want 10", {bus.busy, bus.mem_en});
    end
    reset_n = 1'b0;
    #1;
    outs = {bus.cpu_ack, bus.ldr_ack, bus.mem_en, bus.mem_we, bus.busy, bus.owner,
            bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.ldr_rdata};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL reset_async got %h want 0", outs); end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1 || bus.ldr_ack === 1'b1) acks++;
    end
    vectors++;
    if (acks !== 0) begin miscompares++; $display("FAIL reset_no_ack got %0d acks want 0", acks); end
    do_access(1'b0, 1'b0, 32'h10, '0, -1, '0, lat, en_at, we_s, ab, ob);
    exp_cpu_rd = init_word(4);
    vectors++;
    if (lat !== 2 + TB_LAT) begin miscompares++; $display("FAIL reset_read_lat got %0d want %0d", lat, 2 + TB_LAT); end
    vectors++;
    if (bus.cpu_rdata !== exp_cpu_rd) begin
      miscompares++; $display("FAIL reset_read_data got %h want %h", bus.cpu_rdata, exp_cpu_rd);
    end
  endtask

  task automatic test_write_read();
    int lat, en_at, ab, ob;
    bit we_s;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1, '0, lat, en_at, we_s, ab, ob);
    vectors++;
    if ({lat, en_at} !== {32'd2, 32'd1}) begin
      miscompares++; $display("FAIL cpu_write_timing got ack %0d en %0d want ack 2 en 1", lat, en_at);
    end
    vectors++;
    if ({we_s, ab} !== {1'b1, 32'd0}) begin
      miscompares++; $display("FAIL cpu_write_cmd got we %b addr_bad %0d want we 1 addr_bad 0", we_s, ab);
    end
    do_access(1'b0, 1'b0, 32'h10, '0, -1, '0, lat, en_at, we_s, ab, ob);
    exp_cpu_rd = 32'hDEADBEEF;
    vectors++;
    if ({lat, en_at, we_s} !== {32'(2 + TB_LAT), 32'd1, 1'b0}) begin
      miscompares++; $display("FAIL cpu_read_timing got ack %0d en %0d we %b want ack %0d en 1 we 0", lat, en_at, we_s, 2 + TB_LAT);
    end
    vectors++;
    if (bus.cpu_rdata !== exp_cpu_rd) begin
      miscompares++; $display("FAIL cpu_read_data got %h want %h", bus.cpu_rdata, exp_cpu_rd);
    end
  endtask

  task automatic test_loader_read();
    int lat, en_at, ab, ob;
    bit we_s;
    do_access(1'b1, 1'b1, 32'h40, 32'h12345678, -1, '0, lat, en_at, we_s, ab, ob);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL ldr_write_lat got %0d want 2", lat); end
    do_access(1'b1, 1'b0, 32'h40, '0, -1, '0, lat, en_at, we_s, ab, ob);
    exp_ldr_rd = 32'h12345678;
    vectors++;
    if (lat !== 2 + TB_LAT) begin miscompares++; $display("FAIL ldr_read_lat got %0d want %0d", lat, 2 + TB_LAT); end
    vectors++;
    if (bus.ldr_rdata !== exp_ldr_rd) begin
      miscompares++; $display("FAIL ldr_read_data got %h want %h", bus.ldr_rdata, exp_ldr_rd);
    end
    vectors++;
    if (bus.cpu_rdata !== exp_cpu_rd) begin
      miscompares++; $display("FAIL ldr_cpu_rdata_kept got %h want %h", bus.cpu_rdata, exp_cpu_rd);
    end
    vectors++;
    if (ob !== 0) begin miscompares++; $display("FAIL ldr_owner got %0d wrong-owner cycles want 0", ob); end
  endtask

  task automatic test_contention();
    int grants[10];
    int g = 0, both = 0, passes = 0, want;
    bit done = 1'b0;
    logic [31:0] ca = 32'h80, la = 32'hC0;
    foreach (grants[i]) grants[i] = -1;
    drive(1'b0, 1'b1, 1'b1, ca, $urandom);
    drive(1'b1, 1'b1, 1'b1, la, $urandom);
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        if (g < 10) grants[g] = (bus.owner === 1'b1) ? 1 : 0;
        g++;
      end
      if (bus.cpu_ack === 1'b1 && bus.ldr_ack === 1'b1) both++;
      if (bus.cpu_ack === 1'b1 || bus.ldr_ack === 1'b1) begin
        if (g >= 10) begin
          done = 1'b1;
        end else if (bus.cpu_ack === 1'b1) begin
          ca += 32'd4; drive(1'b0, 1'b1, 1'b1, ca, $urandom);
        end else begin
          la += 32'd4; drive(1'b1, 1'b1, 1'b1, la, $urandom);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      want = (passes == TB_HOLD) ? 1 : 0;
      passes = want ? 0 : passes + 1;
      vectors++;
      if (grants[i] !== want) begin
        miscompares++; $display("FAIL contention_grant[%0d] got %0d want %0d", i, grants[i], want);
      end
    end
    vectors++;
    if (both !== 0) begin miscompares++; $display("FAIL contention_dual_ack got %0d cycles want 0", both); end
  endtask

  task automatic test_back_to_back();
    int issues[4];
    int k = 0, acks = 0, stray = 0;
    logic [31:0] a = 32'h60;
    foreach (issues[i]) issues[i] = -100;
    drive(1'b0, 1'b1, 1'b1, a, $urandom);
    for (int n = 1; n <= 60 && acks < 4; n++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1 && k < 4) begin issues[k] = n; k++; end
      if (bus.ldr_ack === 1'b1) stray++;
      if (bus.cpu_ack === 1'b1) begin
        acks++;
        a += 32'd4;
        if (acks < 4) drive(1'b0, 1'b1, 1'b1, a, $urandom);
        else          drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    vectors++;
    if ({acks, stray, issues[0]} !== {32'd4, 32'd0, 32'd1}) begin
      miscompares++; $display("FAIL b2b_count got acks %0d stray %0d first %0d want 4 0 1", acks, stray, issues[0]);
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (issues[i] - issues[i-1] !== 3) begin
        miscompares++; $display("FAIL b2b_gap[%0d] got %0d want 3", i, issues[i] - issues[i-1]);
      end
    end
  endtask

  task automatic test_field_change();
    int lat, en_at, ab, ob;
    bit we_s;
    do_access(1'b0, 1'b0, 32'h20, '0, 2, 32'h24, lat, en_at, we_s, ab, ob);
    exp_cpu_rd = init_word(8);
    vectors++;
    if ({lat, ab} !== {32'(2 + TB_LAT), 32'd0}) begin
      miscompares++; $display("FAIL field_change_addr got ack %0d addr_bad %0d want %0d 0", lat, ab, 2 + TB_LAT);
    end
    vectors++;
    if (bus.cpu_rdata !== exp_cpu_rd) begin
      miscompares++; $display("FAIL field_change_data got %h want %h", bus.cpu_rdata, exp_cpu_rd);
    end
  endtask

  // Timeline model: accesses are serial; an arbitration happens in any cycle the
  // arbiter is free, and its ack lands 2 (write) or 2+latency (read) cycles later.
  task automatic test_random();
    localparam int STOP  = 800;
    localparam int LIMIT = 1400;
    bit          act [2];
    bit          we_r [2];
    logic [31:0] addr_r [2];
    logic [31:0] wd_r [2];
    logic [31:0] exp_rd [2];
    logic [31:0] ref_mem [256];
    int          next_arb = 0, passes = 0, ack_at = 0;
    bit          busy_m = 1'b0, win = 1'b0, we_g = 1'b0, exp_c, exp_l;
    logic [7:0]  idx;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_rd[0] = exp_cpu_rd;
    exp_rd[1] = exp_ldr_rd;
    act[0] = 1'b0; act[1] = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      exp_c = busy_m && ack_at == c && !win;
      exp_l = busy_m && ack_at == c && win;
      vectors++;
      if ({bus.cpu_ack, bus.ldr_ack} !== {exp_c, exp_l}) begin
        miscompares++; $display("FAIL random_ack cycle %0d got %b%b want %b%b", c, bus.cpu_ack, bus.ldr_ack, exp_c, exp_l);
      end
      if (busy_m && ack_at == c) begin
        vectors++;
        if ({bus.cpu_rdata, bus.ldr_rdata} !== {exp_rd[0], exp_rd[1]}) begin
          miscompares++; $display("FAIL random_rdata cycle %0d got %h/%h want %h/%h", c, bus.cpu_rdata, bus.ldr_rdata, exp_rd[0], exp_rd[1]);
        end
        act[win] = 1'b0;
        busy_m   = 1'b0;
        next_arb = c + 1;
      end
      for (int w = 0; w < 2; w++) begin
        if (!act[w] && c < STOP && $urandom_range(0, 2) != 0) begin
          act[w]    = 1'b1;
          we_r[w]   = 1'($urandom_range(0, 1));
          addr_r[w] = 32'h100 + 32'($urandom_range(0, 15) << 2);
          wd_r[w]   = $urandom;
        end
        drive(1'(w), act[w], we_r[w], addr_r[w], wd_r[w]);
      end
      if (!busy_m && c >= next_arb && (act[0] || act[1])) begin
        win = act[1] && (!act[0] || passes == TB_HOLD);
        passes = (!act[1] || win) ? 0 : passes + 1;
        we_g = we_r[win];
        idx  = addr_r[win][9:2];
        if (we_g) ref_mem[idx] = wd_r[win];
        else      exp_rd[win]  = ref_mem[idx];
        ack_at = c + (we_g ? 2 : 2 + TB_LAT);
        busy_m = 1'b1;
      end
      if (c >= STOP && !act[0] && !act[1] && !busy_m) break;
    end
    vectors++;
    if ({act[0], act[1], busy_m} !== 3'b000) begin
      miscompares++; $display("FAIL random_timeout pending %b%b%b want 000", act[0], act[1], busy_m);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_loader_read();
    test_contention();
    test_back_to_back();
    test_field_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
